// File: rtl/apb_periph_demux.sv
// Registered APB3 demultiplexer: runtime address map, decode-miss errors, saturating error counter.
// Optional per-transfer ACCESS watchdog compiled in with `define APB_DEMUX_TIMEOUT_EN.
module apb_periph_demux #(
   parameter int unsigned NB_SLAVES      = 12,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic [NB_SLAVES-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
   input  logic [NB_SLAVES-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
   input  logic                                          psel_i,
   input  logic                                          penable_i,
   input  logic                                          pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
   output logic                                          pready_o,
   output logic                                          pslverr_o,
   output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
   output logic [NB_SLAVES-1:0]                          psel_o,
   output logic                                          penable_o,
   output logic                                          pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0]                     paddr_o,
   output logic [APB_DATA_WIDTH-1:0]                     pwdata_o,
   input  logic [NB_SLAVES-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
   input  logic [NB_SLAVES-1:0]                          pready_i,
   input  logic [NB_SLAVES-1:0]                          pslverr_i,
   input  logic                                          err_clr_i,
   output logic [15:0]                                   err_count_o,
   output logic [APB_ADDR_WIDTH-1:0]                     last_err_addr_o
);

   localparam int unsigned IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
   localparam int unsigned ERR_W = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   if (NB_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("apb_periph_demux: NB_SLAVES and TIMEOUT_CYCLES must be >= 1");
   end

   logic [1:0]                 state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [APB_ADDR_WIDTH-1:0]  xfer_addr_q, xfer_addr_d;
   logic [APB_ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic                       pwrite_q, pwrite_d;
   logic [NB_SLAVES-1:0]       psel_q, psel_d;
   logic                       penable_q, penable_d;
   logic                       pready_q, pready_d;
   logic                       pslverr_q, pslverr_d;
   logic [APB_DATA_WIDTH-1:0]  prdata_q, prdata_d;
   logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;
   logic [APB_ADDR_WIDTH-1:0]  last_err_q, last_err_d;

   logic                       hit_c;
   logic [IDX_W-1:0]           hit_idx_c;
   logic                       err_evt_c;

`ifdef APB_DEMUX_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0]            wdog_q, wdog_d;
`endif

   // Address decode; descending scan so the lowest matching index wins
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int k = int'(NB_SLAVES) - 1; k >= 0; k--) begin
         if ((paddr_i >= start_addr_i[k]) && (paddr_i < end_addr_i[k])) begin
            hit_c     = 1'b1;
            hit_idx_c = IDX_W'(k);
         end
      end
   end

   // Transfer FSM next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      xfer_addr_d = xfer_addr_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
      prdata_d    = '0;
`ifdef APB_DEMUX_TIMEOUT_EN
      wdog_d      = wdog_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (psel_i && !penable_i) begin
               xfer_addr_d = paddr_i;
               if (hit_c) begin
                  idx_d     = hit_idx_c;
                  paddr_d   = paddr_i;
                  pwdata_d  = pwdata_i;
                  pwrite_d  = pwrite_i;
                  psel_d    = NB_SLAVES'(1) << hit_idx_c;
                  penable_d = 1'b0;
`ifdef APB_DEMUX_TIMEOUT_EN
                  wdog_d    = '0;
`endif
                  state_d   = ST_SETUP;
               end else begin
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
                  state_d   = ST_RESP;
               end
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end

         ST_ACCESS: begin
`ifdef APB_DEMUX_TIMEOUT_EN
            // Select was already dropped when the last allowed cycle expired
            if (wdog_q == WD_W'(TIMEOUT_CYCLES)) begin
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               state_d   = ST_RESP;
            end else if (pready_i[idx_q]) begin
               pready_d  = 1'b1;
               pslverr_d = pslverr_i[idx_q];
               prdata_d  = prdata_i[idx_q];
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = ST_RESP;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
               if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  psel_d    = '0;
                  penable_d = 1'b0;
               end
            end
`else
            if (pready_i[idx_q]) begin
               pready_d  = 1'b1;
               pslverr_d = pslverr_i[idx_q];
               prdata_d  = prdata_i[idx_q];
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = ST_RESP;
            end
`endif
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            psel_d    = '0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Error counter: one event per errored response cycle; clear wins but keeps a coincident event
   always_comb begin
      err_evt_c  = (state_q == ST_RESP) && pslverr_q;
      err_cnt_d  = err_cnt_q;
      last_err_d = last_err_q;
      if (err_evt_c) begin
         last_err_d = xfer_addr_q;
      end
      if (err_clr_i) begin
         err_cnt_d = err_evt_c ? ERR_W'(1) : '0;
      end else if (err_evt_c && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         xfer_addr_q <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
         err_cnt_q   <= '0;
         last_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         xfer_addr_q <= xfer_addr_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         prdata_q    <= prdata_d;
         err_cnt_q   <= err_cnt_d;
         last_err_q  <= last_err_d;
      end
   end

`ifdef APB_DEMUX_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`endif

   assign pready_o        = pready_q;
   assign pslverr_o       = pslverr_q;
   assign prdata_o        = prdata_q;
   assign psel_o          = psel_q;
   assign penable_o       = penable_q;
   assign pwrite_o        = pwrite_q;
   assign paddr_o         = paddr_q;
   assign pwdata_o        = pwdata_q;
   assign err_count_o     = err_cnt_q;
   assign last_err_addr_o = last_err_q;

endmodule

// File: tb/tb_apb_periph_demux.sv
// Directed self-checking bench for apb_periph_demux (12 slaves, TIMEOUT_CYCLES=4).
module tb_apb_periph_demux;

   localparam int unsigned NB = 12;
   localparam int unsigned TO = 4;

   logic                  clk_i;
   logic                  rst_ni;
   logic [NB-1:0][31:0]   start_addr_i;
   logic [NB-1:0][31:0]   end_addr_i;
   logic                  psel_i;
   logic                  penable_i;
   logic                  pwrite_i;
   logic [31:0]           paddr_i;
   logic [31:0]           pwdata_i;
   logic                  pready_o;
   logic                  pslverr_o;
   logic [31:0]           prdata_o;
   logic [NB-1:0]         psel_o;
   logic                  penable_o;
   logic                  pwrite_o;
   logic [31:0]           paddr_o;
   logic [31:0]           pwdata_o;
   logic [NB-1:0][31:0]   prdata_i;
   logic [NB-1:0]         pready_i;
   logic [NB-1:0]         pslverr_i;
   logic                  err_clr_i;
   logic [15:0]           err_count_o;
   logic [31:0]           last_err_addr_o;

   int          checks   = 0;
   int          failures = 0;
   int          wait_states = 0;
   int          acc_cnt  = 0;
   logic [NB-1:0] slverr_mask = '0;

   int          x_lat;
   logic [31:0] x_rdata;
   logic        x_err;
   logic [NB-1:0] sel_hist [0:63];
   logic          en_hist  [0:63];

   apb_periph_demux #(
      .NB_SLAVES      (NB),
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .start_addr_i    (start_addr_i),
      .end_addr_i      (end_addr_i),
      .psel_i          (psel_i),
      .penable_i       (penable_i),
      .pwrite_i        (pwrite_i),
      .paddr_i         (paddr_i),
      .pwdata_i        (pwdata_i),
      .pready_o        (pready_o),
      .pslverr_o       (pslverr_o),
      .prdata_o        (prdata_o),
      .psel_o          (psel_o),
      .penable_o       (penable_o),
      .pwrite_o        (pwrite_o),
      .paddr_o         (paddr_o),
      .pwdata_o        (pwdata_o),
      .prdata_i        (prdata_i),
      .pready_i        (pready_i),
      .pslverr_i       (pslverr_i),
      .err_clr_i       (err_clr_i),
      .err_count_o     (err_count_o),
      .last_err_addr_o (last_err_addr_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Slave model: ready after wait_states ACCESS cycles, fixed per-slave read data
   always @(posedge clk_i) acc_cnt <= ((|psel_o) && penable_o) ? acc_cnt + 1 : 0;

   always_comb begin
      for (int k = 0; k < int'(NB); k++) begin
         prdata_i[k] = 32'hD000_0000 | 32'(k);
         pready_i[k] = psel_o[k] & penable_o & (acc_cnt >= wait_states);
      end
   end
   assign pslverr_i = slverr_mask;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // One upstream transfer starting at a negedge; x_lat = cycles from SETUP to pready_o
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic clr);
      psel_i    = 1'b1;
      penable_i = 1'b0;
      paddr_i   = addr;
      pwrite_i  = wr;
      pwdata_i  = wdata;
      x_lat     = 0;
      do begin
         cyc();
         x_lat++;
         sel_hist[x_lat] = psel_o;
         en_hist[x_lat]  = penable_o;
         penable_i = 1'b1;
      end while (!pready_o && x_lat < 40);
      x_rdata = prdata_o;
      x_err   = pslverr_o;
      if (!pready_o) check_eq("xfer_done", 32'(pready_o), 32'd1);
      err_clr_i = clr;
      cyc();
      err_clr_i = 1'b0;
      psel_i    = 1'b0;
      penable_i = 1'b0;
   endtask

   initial begin
      rst_ni    = 1'b0;
      psel_i    = 1'b0;
      penable_i = 1'b0;
      pwrite_i  = 1'b0;
      paddr_i   = '0;
      pwdata_i  = '0;
      err_clr_i = 1'b0;
      for (int k = 0; k < int'(NB); k++) begin
         start_addr_i[k] = 32'h2000_0000 + 32'(k) * 32'h1000;
         end_addr_i[k]   = start_addr_i[k] + 32'h1000;
      end
      start_addr_i[1] = 32'h1A10_1000;  end_addr_i[1] = 32'h1A10_3000;
      start_addr_i[5] = 32'h1A10_2000;  end_addr_i[5] = 32'h1A10_2100;
      start_addr_i[7] = 32'h3000_0000;  end_addr_i[7] = 32'h3000_0000;
      start_addr_i[8] = 32'h4000_1000;  end_addr_i[8] = 32'h4000_0000;

      repeat (2) @(negedge clk_i);
      check_eq("rst_pready",  32'(pready_o), 32'd0);
      check_eq("rst_psel",    32'(psel_o), 32'd0);
      check_eq("rst_penable", 32'(penable_o), 32'd0);
      check_eq("rst_errcnt",  32'(err_count_o), 32'd0);
      check_eq("rst_paddr",   paddr_o, 32'd0);
      rst_ni = 1'b1;
      cyc();

      // Zero-wait write to region 3
      apb_xfer(32'h2000_3000, 1'b1, 32'hCAFE_BABE, 1'b0);
      check_eq("wr_lat",     32'(x_lat), 32'd3);
      check_eq("wr_sel1",    32'(sel_hist[1]), 32'h008);
      check_eq("wr_en1",     32'(en_hist[1]), 32'd0);
      check_eq("wr_sel2",    32'(sel_hist[2]), 32'h008);
      check_eq("wr_en2",     32'(en_hist[2]), 32'd1);
      check_eq("wr_err",     32'(x_err), 32'd0);
      check_eq("wr_pwdata",  pwdata_o, 32'hCAFE_BABE);
      check_eq("wr_paddr",   paddr_o, 32'h2000_3000);
      check_eq("wr_pwrite",  32'(pwrite_o), 32'd1);
      check_eq("wr_sel_off", 32'(psel_o), 32'd0);
      check_eq("wr_errcnt",  32'(err_count_o), 32'd0);

      // Overlap: regions 1 and 5 both hold the address, lowest index wins
      apb_xfer(32'h1A10_2000, 1'b0, 32'h0, 1'b0);
      check_eq("ovl_sel",   32'(sel_hist[1]), 32'h002);
      check_eq("ovl_rdata", x_rdata, 32'hD000_0001);
      check_eq("ovl_lat",   32'(x_lat), 32'd3);

      // Unmapped read
      apb_xfer(32'hFFFF_0000, 1'b0, 32'h0, 1'b0);
      check_eq("miss_lat",     32'(x_lat), 32'd1);
      check_eq("miss_err",     32'(x_err), 32'd1);
      check_eq("miss_rdata",   x_rdata, 32'd0);
      check_eq("miss_sel",     32'(sel_hist[1]), 32'd0);
      check_eq("miss_errcnt",  32'(err_count_o), 32'd1);
      check_eq("miss_lastadr", last_err_addr_o, 32'hFFFF_0000);
      check_eq("miss_paddr_hold", paddr_o, 32'h1A10_2000);

      // Inverted region never matches
      apb_xfer(32'h4000_0800, 1'b0, 32'h0, 1'b0);
      check_eq("inv_err",    32'(x_err), 32'd1);
      check_eq("inv_errcnt", 32'(err_count_o), 32'd2);

      // End address is exclusive
      apb_xfer(32'h2000_4000, 1'b0, 32'h0, 1'b0);
      check_eq("bnd_sel4",  32'(sel_hist[1]), 32'h010);
      apb_xfer(32'h2000_BFFF, 1'b0, 32'h0, 1'b0);
      check_eq("bnd_sel11", 32'(sel_hist[1]), 32'h800);
      check_eq("bnd_rd11",  x_rdata, 32'hD000_000B);
      apb_xfer(32'h2000_C000, 1'b0, 32'h0, 1'b0);
      check_eq("bnd_miss",  32'(x_err), 32'd1);
      check_eq("bnd_errcnt", 32'(err_count_o), 32'd3);

      // Two slave wait states, then slave error
      wait_states = 2;
      apb_xfer(32'h2000_0010, 1'b0, 32'h0, 1'b0);
      check_eq("ws2_lat", 32'(x_lat), 32'd5);
      check_eq("ws2_err", 32'(x_err), 32'd0);
      wait_states = 0;
      slverr_mask = 12'h004;
      apb_xfer(32'h2000_2004, 1'b0, 32'h0, 1'b0);
      slverr_mask = '0;
      check_eq("slv_err",     32'(x_err), 32'd1);
      check_eq("slv_rdata",   x_rdata, 32'hD000_0002);
      check_eq("slv_errcnt",  32'(err_count_o), 32'd4);
      check_eq("slv_lastadr", last_err_addr_o, 32'h2000_2004);

      // Ready on the last permitted ACCESS cycle succeeds
      wait_states = 3;
      apb_xfer(32'h2000_3000, 1'b0, 32'h0, 1'b0);
      check_eq("last_ok_lat", 32'(x_lat), 32'd6);
      check_eq("last_ok_err", 32'(x_err), 32'd0);

      wait_states = 10;
      apb_xfer(32'h2000_3000, 1'b0, 32'h0, 1'b0);
`ifdef APB_DEMUX_TIMEOUT_EN
      check_eq("to_lat",    32'(x_lat), 32'd7);
      check_eq("to_err",    32'(x_err), 32'd1);
      check_eq("to_rdata",  x_rdata, 32'd0);
      check_eq("to_sel5",   32'(sel_hist[5]), 32'h008);
      check_eq("to_sel6",   32'(sel_hist[6]), 32'd0);
      check_eq("to_errcnt", 32'(err_count_o), 32'd5);
`else
      check_eq("stall_lat",    32'(x_lat), 32'd13);
      check_eq("stall_err",    32'(x_err), 32'd0);
      check_eq("stall_rdata",  x_rdata, 32'hD000_0003);
      check_eq("stall_errcnt", 32'(err_count_o), 32'd4);
`endif
      wait_states = 0;

      // Saturation from a preset near the top
      force dut.err_cnt_q = 16'hFFFE;
      cyc();
      release dut.err_cnt_q;
      cyc();
      check_eq("sat_preset", 32'(err_count_o), 32'h0000_FFFE);
      apb_xfer(32'hFFFF_1000, 1'b0, 32'h0, 1'b0);
      check_eq("sat_top",  32'(err_count_o), 32'h0000_FFFF);
      apb_xfer(32'hFFFF_2000, 1'b0, 32'h0, 1'b0);
      check_eq("sat_hold", 32'(err_count_o), 32'h0000_FFFF);
      check_eq("sat_lastadr", last_err_addr_o, 32'hFFFF_2000);

      // Clear together with an error gives 1, clear alone gives 0
      apb_xfer(32'hFFFF_3000, 1'b0, 32'h0, 1'b1);
      check_eq("clr_evt", 32'(err_count_o), 32'd1);
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      check_eq("clr_only", 32'(err_count_o), 32'd0);

      // Asynchronous reset in the middle of ACCESS
      wait_states = 1000;
      psel_i    = 1'b1;
      penable_i = 1'b0;
      paddr_i   = 32'h2000_6000;
      pwrite_i  = 1'b0;
      cyc();
      penable_i = 1'b1;
      cyc();
      cyc();
      check_eq("arst_pre_sel", 32'(psel_o), 32'h040);
      rst_ni = 1'b0;
      #1;
      check_eq("arst_sel",    32'(psel_o), 32'd0);
      check_eq("arst_penable", 32'(penable_o), 32'd0);
      check_eq("arst_pready", 32'(pready_o), 32'd0);
      psel_i    = 1'b0;
      penable_i = 1'b0;
      wait_states = 0;
      cyc();
      rst_ni = 1'b1;
      cyc();
      apb_xfer(32'h2000_9000, 1'b1, 32'h1234_5678, 1'b0);
      check_eq("post_lat",    32'(x_lat), 32'd3);
      check_eq("post_err",    32'(x_err), 32'd0);
      check_eq("post_sel",    32'(sel_hist[2]), 32'h200);
      check_eq("post_pwdata", pwdata_o, 32'h1234_5678);
      check_eq("post_errcnt", 32'(err_count_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
